mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_pkg.sv | 38 +++
 rtl/load_extend.sv | 21 ++
 rtl/mem_access_unit.sv | 134 +++++++++++++
 tb/tb_mem_access_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared funct3 codes, FSM states and access-size helpers
package mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} state_t;

  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Legal opcode for the direction and naturally aligned for its size.
  function automatic logic access_ok(input logic write, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic legal;
    logic aligned;
    if (write) legal = funct3 inside {SB, SH, SW};
    else       legal = funct3 inside {LB, LH, LW, LBU, LHU};
    case (funct3[1:0])
      2'b01:   aligned = ~addr_lo[0];
      2'b10:   aligned = (addr_lo == 2'b00);
      default: aligned = 1'b1;
    endcase
    return legal && aligned;
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - sign/zero extension of assembled load data
module load_extend
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    case (funct3)
      LB:      data = {{24{raw[7]}}, raw[7:0]};
      LH:      data = {{16{raw[15]}}, raw[15:0]};
      LBU:     data = {24'h000000, raw[7:0]};
      LHU:     data = {16'h0000, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - splits word/half/byte loads and stores into byte-memory accesses
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  state_t      state;
  logic [1:0]  idx;
  logic [1:0]  nidx;
  logic [2:0]  funct3_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [31:0] raw;
  logic [31:0] raw_next;
  logic [31:0] ext_data;
  logic        cap_valid;
  logic [1:0]  cap_lane;
  logic        last;

  // Read data lags mem_en by one cycle, so lanes are filled one cycle behind the strobe.
  always_comb begin
    raw_next = raw;
    if (cap_valid) raw_next[{cap_lane, 3'b000} +: 8] = mem_rdata;
  end

  assign nidx = idx + 2'd1;
  assign last = ({1'b0, idx} == (size_to_n(funct3_q[1:0]) - 3'd1));

  load_extend u_load_extend (
    .funct3 (funct3_q),
    .raw    (raw_next),
    .data   (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      idx       <= '0;
      funct3_q  <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      raw       <= '0;
      cap_valid <= 1'b0;
      cap_lane  <= '0;
    end else begin
      raw       <= raw_next;
      cap_valid <= mem_en & ~mem_we;
      cap_lane  <= idx;
      case (state)
        IDLE: begin
          if (req_ready && req_valid) begin
            req_ready <= 1'b0;
            funct3_q  <= req_funct3;
            write_q   <= req_write;
            wdata_q   <= req_wdata;
            raw       <= '0;
            idx       <= '0;
            if (access_ok(req_write, req_funct3, req_addr[1:0])) begin
              state     <= XFER;
              mem_en    <= 1'b1;
              mem_we    <= req_write;
              mem_addr  <= req_addr;
              mem_wdata <= req_wdata[7:0];
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        XFER: begin
          if (last) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (write_q) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= '0;
            end else begin
              state <= DRAIN;
            end
          end else begin
            idx       <= nidx;
            mem_addr  <= mem_addr + 32'd1;
            mem_wdata <= wdata_q[{nidx, 3'b000} +: 8];
          end
        end
        DRAIN: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= ext_data;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:4095];
  int          ncmp = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Byte memory, 4 KiB aliased on the low address bits; read data appears one cycle later.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[11:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge; returns in cycle 1 of the access.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    req_valid  = 1'b1;
    tick();
    req_valid  = 1'b0;
  endtask

  logic [7:0] sw_bytes [0:3];

  initial begin
    sw_bytes[0] = 8'hEF; sw_bytes[1] = 8'hBE; sw_bytes[2] = 8'hAD; sw_bytes[3] = 8'hDE;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h200] = 8'h80;
    mem[12'h300] = 8'h78; mem[12'h301] = 8'h56; mem[12'h302] = 8'h34; mem[12'h303] = 8'h12;
    mem_rdata  = 8'h00;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;

    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // SW 0x100 <- 0xDEADBEEF
    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sw_en%0d", i), {31'd0, mem_en}, 32'd1);
      chk($sformatf("sw_we%0d", i), {31'd0, mem_we}, 32'd1);
      chk($sformatf("sw_addr%0d", i), mem_addr, 32'h100 + i);
      chk($sformatf("sw_wdata%0d", i), {24'd0, mem_wdata}, {24'd0, sw_bytes[i]});
      chk($sformatf("sw_rspv%0d", i), {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    chk("sw_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("sw_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("sw_mem_en_c5", {31'd0, mem_en}, 32'd0);
    chk("sw_mem", {mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]}, 32'hDEADBEEF);
    tick();
    chk("sw_rsp_drop", {31'd0, rsp_valid}, 32'd0);
    chk("sw_ready", {31'd0, req_ready}, 32'd1);

    // LB / LBU 0x200 holding 0x80
    issue(1'b0, 3'b000, 32'h200, 32'h0);
    chk("lb_en", {31'd0, mem_en}, 32'd1);
    chk("lb_we", {31'd0, mem_we}, 32'd0);
    chk("lb_addr", mem_addr, 32'h200);
    tick();
    chk("lb_c2_en", {31'd0, mem_en}, 32'd0);
    chk("lb_c2_rspv", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("lb_rspv", {31'd0, rsp_valid}, 32'd1);
    chk("lb_rdata", rsp_rdata, 32'hFFFFFF80);
    tick();
    chk("lb_ready", {31'd0, req_ready}, 32'd1);
    issue(1'b0, 3'b100, 32'h200, 32'h0);
    tick();
    tick();
    chk("lbu_rspv", {31'd0, rsp_valid}, 32'd1);
    chk("lbu_rdata", rsp_rdata, 32'h00000080);
    tick();

    // LH / LHU 0x102 -> halfword 0xDEAD from the earlier store, response in cycle 4
    issue(1'b0, 3'b001, 32'h102, 32'h0);
    tick(); tick();
    chk("lh_c3_rspv", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("lh_rspv", {31'd0, rsp_valid}, 32'd1);
    chk("lh_rdata", rsp_rdata, 32'hFFFFDEAD);
    tick();
    issue(1'b0, 3'b101, 32'h102, 32'h0);
    tick(); tick(); tick();
    chk("lhu_rdata", rsp_rdata, 32'h0000DEAD);
    tick();

    // Misaligned LH and illegal funct3 011
    issue(1'b0, 3'b001, 32'h201, 32'h0);
    chk("mis_rspv", {31'd0, rsp_valid}, 32'd1);
    chk("mis_err", {31'd0, rsp_err}, 32'd1);
    chk("mis_rdata", rsp_rdata, 32'd0);
    chk("mis_en", {31'd0, mem_en}, 32'd0);
    tick();
    chk("mis_ready", {31'd0, req_ready}, 32'd1);
    chk("mis_en2", {31'd0, mem_en}, 32'd0);
    issue(1'b0, 3'b011, 32'h300, 32'h0);
    chk("ill_rspv", {31'd0, rsp_valid}, 32'd1);
    chk("ill_err", {31'd0, rsp_err}, 32'd1);
    chk("ill_en", {31'd0, mem_en}, 32'd0);
    tick();

    // LW 0x300 with a following LBU request held throughout the access
    issue(1'b0, 3'b010, 32'h300, 32'h0);
    req_funct3 = 3'b100;
    req_addr   = 32'h200;
    req_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lw_en%0d", i), {31'd0, mem_en}, 32'd1);
      chk($sformatf("lw_addr%0d", i), mem_addr, 32'h300 + i);
      chk($sformatf("lw_busy%0d", i), {31'd0, req_ready}, 32'd0);
      tick();
    end
    chk("lw_drain_en", {31'd0, mem_en}, 32'd0);
    chk("lw_drain_rspv", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("lw_rspv", {31'd0, rsp_valid}, 32'd1);
    chk("lw_rdata", rsp_rdata, 32'h12345678);
    chk("lw_rsp_ready", {31'd0, req_ready}, 32'd0);
    tick();
    chk("held_ready", {31'd0, req_ready}, 32'd1);
    chk("held_not_yet", {31'd0, mem_en}, 32'd0);
    tick();
    req_valid = 1'b0;
    chk("held_en", {31'd0, mem_en}, 32'd1);
    chk("held_addr", mem_addr, 32'h200);
    tick(); tick();
    chk("held_rdata", rsp_rdata, 32'h00000080);
    tick();

    // Reset in cycle 2 of a SW
    issue(1'b1, 3'b010, 32'h110, 32'h11223344);
    tick();
    chk("abort_c2_en", {31'd0, mem_en}, 32'd1);
    chk("abort_c2_addr", mem_addr, 32'h111);
    rst_n = 1'b0;
    #1;
    chk("abort_en", {31'd0, mem_en}, 32'd0);
    chk("abort_we", {31'd0, mem_we}, 32'd0);
    chk("abort_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd0);
    chk("abort_byte0", {24'd0, mem[12'h110]}, 32'h44);
    chk("abort_byte1", {24'd0, mem[12'h111]}, 32'h00);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("abort_ready_rel", {31'd0, req_ready}, 32'd1);
    chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("abort_no_rsp2", {31'd0, rsp_valid}, 32'd0);

    // SB / LBU at the top of the address space
    issue(1'b1, 3'b000, 32'hFFFFFFFF, 32'h000000A5);
    chk("top_sb_addr", mem_addr, 32'hFFFFFFFF);
    chk("top_sb_wdata", {24'd0, mem_wdata}, 32'hA5);
    tick();
    chk("top_sb_rspv", {31'd0, rsp_valid}, 32'd1);
    chk("top_sb_err", {31'd0, rsp_err}, 32'd0);
    tick();
    chk("top_sb_ready", {31'd0, req_ready}, 32'd1);
    issue(1'b0, 3'b100, 32'hFFFFFFFF, 32'h0);
    chk("top_lbu_addr", mem_addr, 32'hFFFFFFFF);
    chk("top_lbu_we", {31'd0, mem_we}, 32'd0);
    tick(); tick();
    chk("top_lbu_rspv", {31'd0, rsp_valid}, 32'd1);
    chk("top_lbu_rdata", rsp_rdata, 32'h000000A5);
    tick();
    chk("top_lbu_ready", {31'd0, req_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
